// File: rtl/ysyx_23060096_pkg.sv
// rtl/ysyx_23060096_pkg.sv - shared MemOP codes and LSU state encoding
//
// Purpose: constants shared by the LSU and its helpers.
//   MEMOP_*     : RISC-V func3 width/sign codes carried on MemOP
//   lsu_state_e : LSU transaction FSM states
package ysyx_23060096_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_23060096_lsu_if.sv
// rtl/ysyx_23060096_lsu_if.sv - data-memory port between LSU and memory
//
// Purpose: bundles the LSU data-memory request/response bus.
//   mem_req_valid/mem_req_ready : request handshake
//   mem_addr, mem_wen, mem_wdata, mem_wmask : request payload (word aligned)
//   mem_resp_valid, mem_rdata   : response strobe and word read data
// Modports: master = LSU side, slave = memory side.
interface ysyx_23060096_lsu_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/ysyx_23060096_lsu_ext.sv
// rtl/ysyx_23060096_lsu_ext.sv - load byte/halfword extraction and extension
//
// Purpose: pulls the addressed lane out of a memory word and extends it.
//   mem_rdata : 32-bit word as returned by memory
//   addr      : byte offset within the word
//   MemOP     : width/sign code
//   result    : right-aligned, sign/zero-extended load value
// Purely combinational so a cache refill path can reuse it.
module ysyx_23060096_lsu_ext
  import ysyx_23060096_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  MemOP,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = mem_rdata >> {addr, 3'b000};

  always_comb begin
    result = shifted;
    case (MemOP)
      MEMOP_B:  result = {{24{shifted[7]}}, shifted[7:0]};
      MEMOP_H:  result = {{16{shifted[15]}}, shifted[15:0]};
      MEMOP_BU: result = {24'h0, shifted[7:0]};
      MEMOP_HU: result = {16'h0, shifted[15:0]};
      default:  result = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_23060096_lsu.sv
// rtl/ysyx_23060096_lsu.sv - single-outstanding load/store unit
//
// Purpose: takes one memory op from execute, steers store lanes, runs one
// transaction on the data-memory port and returns extended load data or a
// store acknowledge to writeback.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake from execute
//   MemWr, MemtoReg, MemOP: store / load / width-sign controls
//   addr, wdata           : byte address and right-aligned store data
//   mem                   : data-memory port (master side)
//   resp_valid/resp_ready : result handshake to writeback
//   resp_rdata, resp_err  : load result (0 for stores), error flag
module ysyx_23060096_lsu
  import ysyx_23060096_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      MemWr,
  input  logic                      MemtoReg,
  input  logic [2:0]                MemOP,
  input  logic [XLEN-1:0]           addr,
  input  logic [XLEN-1:0]           wdata,
  ysyx_23060096_lsu_if.master       mem,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [XLEN-1:0]           resp_rdata,
  output logic                      resp_err
);

  lsu_state_e  state;
  logic [2:0]  op_r;
  logic [1:0]  lo_r;
  logic        load_r;

  logic        is_mem;
  logic        op_err;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  // Store wins when both controls are set.
  assign is_mem    = MemWr | MemtoReg;
  assign req_ready = (state == LSU_IDLE);

  always_comb begin
    case (MemOP)
      MEMOP_B, MEMOP_BU: op_err = 1'b0;
      MEMOP_H, MEMOP_HU: op_err = addr[0];
      MEMOP_W:           op_err = |addr[1:0];
      default:           op_err = 1'b1;
    endcase
  end

  // Data is replicated across lanes so the strobe alone selects the bytes.
  always_comb begin
    st_mask = 4'b0000;
    st_data = 32'h0;
    case (MemOP[1:0])
      2'b00: begin
        st_mask = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << addr[1:0];
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = wdata[31:0];
      end
    endcase
  end

  ysyx_23060096_lsu_ext u_ext (
    .mem_rdata (mem.mem_rdata),
    .addr      (lo_r),
    .MemOP     (op_r),
    .result    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= LSU_IDLE;
      op_r              <= 3'b000;
      lo_r              <= 2'b00;
      load_r            <= 1'b0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_addr      <= 32'h0;
      mem.mem_wen       <= 1'b0;
      mem.mem_wdata     <= 32'h0;
      mem.mem_wmask     <= 4'b0000;
      resp_valid        <= 1'b0;
      resp_rdata        <= '0;
      resp_err          <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            op_r   <= MemOP;
            lo_r   <= addr[1:0];
            load_r <= MemtoReg & ~MemWr;
            if (!is_mem || op_err) begin
              // No-ops and errors complete without touching the bus.
              state      <= LSU_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= is_mem;
            end else begin
              state             <= LSU_REQ;
              mem.mem_req_valid <= 1'b1;
              mem.mem_addr      <= {addr[31:2], 2'b00};
              mem.mem_wen       <= MemWr;
              mem.mem_wdata     <= MemWr ? st_data : 32'h0;
              mem.mem_wmask     <= MemWr ? st_mask : 4'b0000;
            end
          end
        end
        LSU_REQ: begin
          if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            state             <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (mem.mem_resp_valid) begin
            resp_valid <= 1'b1;
            resp_rdata <= load_r ? ld_data : '0;
            resp_err   <= 1'b0;
            state      <= LSU_RESP;
          end
        end
        LSU_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_lsu.sv
// tb/tb_ysyx_23060096_lsu.sv - self-checking bench for ysyx_23060096_lsu
module tb_ysyx_23060096_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        MemWr = 1'b0;
  logic        MemtoReg = 1'b0;
  logic [2:0]  MemOP = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  ysyx_23060096_lsu_if mif();

  ysyx_23060096_lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .MemWr      (MemWr),
    .MemtoReg   (MemtoReg),
    .MemOP      (MemOP),
    .addr       (addr),
    .wdata      (wdata),
    .mem        (mif),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic        ld;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rw;
    logic        bus;
    logic        err;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [3:0]  mask;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[12];

  logic        g_bus, g_wen, g_err;
  logic [31:0] g_maddr, g_mwd, g_rdata;
  logic [3:0]  g_mask;
  int          g_lat;

  logic        e_bus, e_err;
  logic [31:0] e_maddr, e_mwd, e_rdata;
  logic [3:0]  e_mask;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"},     32'(req_ready), 32'd1);
    check({tag, "_mem_req_valid"}, 32'(mif.mem_req_valid), 32'd0);
    check({tag, "_mem_wen"},       32'(mif.mem_wen), 32'd0);
    check({tag, "_mem_wmask"},     32'(mif.mem_wmask), 32'd0);
    check({tag, "_mem_addr"},      mif.mem_addr, 32'd0);
    check({tag, "_mem_wdata"},     mif.mem_wdata, 32'd0);
    check({tag, "_resp_valid"},    32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"},    resp_rdata, 32'd0);
    check({tag, "_resp_err"},      32'(resp_err), 32'd0);
  endtask

  // Reference: bytes of the word are selected by offset and width, then the
  // value is reinterpreted as signed where the opcode asks for it.
  function automatic void model(input logic wr, input logic ld, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                                output logic bus, output logic err, output logic [31:0] maddr,
                                output logic [31:0] mwd, output logic [3:0] mask,
                                output logic [31:0] rdata);
    int     size;
    int     lo;
    longint v;
    longint full;
    bit     illegal;
    lo      = int'(a % 32'd4);
    size    = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    illegal = (op == 3'd3) || (op >= 3'd6);
    err     = (wr || ld) && (illegal || ((a % 32'(size)) != 32'd0));
    bus     = (wr || ld) && !err;
    maddr   = a - (a % 32'd4);
    mask    = 4'b0000;
    mwd     = 32'h0;
    rdata   = 32'h0;
    if (bus && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= lo && i < lo + size) mask[i] = 1'b1;
        mwd = mwd | (((wd >> (8 * (i % size))) & 32'hFF) << (8 * i));
      end
    end else if (bus) begin
      full = longint'(1) << (8 * size);
      v    = longint'(rw >> (8 * lo)) % full;
      if (op < 3'd4 && size < 4 && v >= full / 2) v = v - full;
      rdata = v[31:0];
    end
  endfunction

  task automatic do_op(input logic wr, input logic ld, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                       input int rqs, input int ml, input int rss);
    logic hs, gave, done, fin;
    int   rq, wc, rs;
    g_bus = 0; g_maddr = 0; g_mwd = 0; g_mask = 0; g_wen = 0;
    g_rdata = 0; g_err = 0; g_lat = 0;
    hs = 0; gave = 0; done = 0; fin = 0; rq = 0; wc = 0; rs = 0;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; MemWr = wr; MemtoReg = ld; MemOP = op; addr = a; wdata = wd;
    tick;
    req_valid = 1'b0; MemWr = 1'($urandom); MemtoReg = 1'($urandom);
    MemOP = 3'($urandom); addr = $urandom; wdata = $urandom;
    for (int c = 1; c <= 64 && !done; c++) begin
      if (c == 1) check("req_ready_busy", 32'(req_ready), 32'd0);
      mif.mem_resp_valid = hs ? 1'b0 : 1'($urandom);
      mif.mem_rdata      = $urandom;
      if (hs && !gave) begin
        if (wc == ml) begin
          mif.mem_resp_valid = 1'b1;
          mif.mem_rdata      = rw;
          gave               = 1'b1;
        end else begin
          wc++;
        end
      end
      if (mif.mem_req_valid) begin
        if (!g_bus) begin
          g_bus = 1'b1; g_maddr = mif.mem_addr; g_mwd = mif.mem_wdata;
          g_mask = mif.mem_wmask; g_wen = mif.mem_wen;
        end else begin
          check("req_hold_addr",  mif.mem_addr, g_maddr);
          check("req_hold_wdata", mif.mem_wdata, g_mwd);
          check("req_hold_wmask", 32'(mif.mem_wmask), 32'(g_mask));
          check("req_hold_wen",   32'(mif.mem_wen), 32'(g_wen));
        end
        mif.mem_req_ready = (rq >= rqs);
        rq++;
        if (mif.mem_req_ready) hs = 1'b1;
      end else begin
        mif.mem_req_ready = 1'($urandom);
      end
      if (resp_valid) begin
        if (g_lat == 0) begin
          g_lat = c; g_rdata = resp_rdata; g_err = resp_err;
        end else begin
          check("resp_hold_rdata", resp_rdata, g_rdata);
          check("resp_hold_err",   32'(resp_err), 32'(g_err));
        end
        resp_ready = (rs >= rss);
        rs++;
        if (!resp_ready) begin
          mif.mem_resp_valid = 1'b1;
          mif.mem_rdata      = ~g_rdata;
        end else begin
          fin = 1'b1;
        end
      end else begin
        resp_ready = 1'($urandom);
      end
      tick;
      if (fin) done = 1'b1;
    end
    check("op_done", 32'(done), 32'd1);
    resp_ready = 1'b0; mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0;
  endtask

  task automatic compare(input string tag, input logic wr, input logic bus, input logic err,
                         input logic [31:0] maddr, input logic [31:0] mwd,
                         input logic [3:0] mask, input logic [31:0] rdata, input int lat);
    check({tag, "_bus"},   32'(g_bus), 32'(bus));
    check({tag, "_err"},   32'(g_err), 32'(err));
    check({tag, "_rdata"}, g_rdata, rdata);
    check({tag, "_lat"},   32'(g_lat), 32'(lat));
    if (bus) begin
      check({tag, "_maddr"}, g_maddr, maddr);
      check({tag, "_mwd"},   g_mwd, mwd);
      check({tag, "_mask"},  32'(g_mask), 32'(mask));
      check({tag, "_wen"},   32'(g_wen), 32'(wr));
    end
  endtask

  initial begin
    logic        wr, ld;
    logic [2:0]  op;
    logic [31:0] a, wd, rw;
    int          rqs, ml, rss;

    vt[0]  = '{1'b1, 1'b0, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,
               1'b1, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 3'd0, 32'h8000_0003, 32'h0000_00A5, 32'h0,
               1'b1, 1'b0, 32'h8000_0000, 32'hA5A5_A5A5, 4'b1000, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 3'd0, 32'h8000_0002, 32'h0, 32'h80FF_7F01,
               1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FFFF};
    vt[3]  = '{1'b0, 1'b1, 3'd4, 32'h8000_0002, 32'h0, 32'h80FF_7F01,
               1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_00FF};
    vt[4]  = '{1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'h0, 32'h8001_1234,
               1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_8001};
    vt[5]  = '{1'b0, 1'b1, 3'd5, 32'h8000_0002, 32'h0, 32'h8001_1234,
               1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_8001};
    vt[6]  = '{1'b0, 1'b1, 3'd2, 32'h8000_0002, 32'h0, 32'h1111_1111,
               1'b0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 3'd1, 32'h8000_0002, 32'h1234_ABCD, 32'h0,
               1'b1, 1'b0, 32'h8000_0000, 32'hABCD_ABCD, 4'b1100, 32'h0};
    vt[8]  = '{1'b0, 1'b0, 3'd7, 32'h0000_0003, 32'h5555_5555, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 3'd2, 32'h8000_0008, 32'h0, 32'h1234_5678,
               1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'b0000, 32'h1234_5678};
    vt[10] = '{1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'h0, 32'h0,
               1'b0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0};
    vt[11] = '{1'b0, 1'b1, 3'd0, 32'h8000_0001, 32'h0, 32'h0000_8000,
               1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80};

    mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0; mif.mem_rdata = 32'h0;
    tick;
    tick;
    check_reset("por");
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 12; i++) begin
      do_op(vt[i].wr, vt[i].ld, vt[i].op, vt[i].a, vt[i].wd, vt[i].rw, 0, 0, 0);
      compare($sformatf("vec%0d", i), vt[i].wr, vt[i].bus, vt[i].err, vt[i].maddr,
              vt[i].mwd, vt[i].mask, vt[i].rdata, vt[i].bus ? 3 : 1);
    end

    // Backpressure on both sides plus one wait state in memory.
    do_op(1'b1, 1'b0, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 3, 1, 5);
    compare("bp_sw", 1'b1, 1'b1, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0, 7);
    do_op(1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'h0, 32'h8001_1234, 2, 2, 5);
    compare("bp_lh", 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_8001, 7);

    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom);
      ld  = 1'($urandom);
      op  = 3'($urandom);
      a   = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      wd  = $urandom;
      rw  = $urandom;
      rqs = int'($urandom_range(0, 2));
      ml  = int'($urandom_range(0, 2));
      rss = int'($urandom_range(0, 2));
      do_op(wr, ld, op, a, wd, rw, rqs, ml, rss);
      model(wr, ld, op, a, wd, rw, e_bus, e_err, e_maddr, e_mwd, e_mask, e_rdata);
      compare($sformatf("rnd%0d", i), wr, e_bus, e_err, e_maddr, e_mwd, e_mask, e_rdata,
              e_bus ? 3 + rqs + ml : 1);
    end

    // Reset while a load waits for memory.
    req_valid = 1'b1; MemWr = 1'b0; MemtoReg = 1'b1; MemOP = 3'd2; addr = 32'h8000_0010;
    tick;
    req_valid = 1'b0;
    mif.mem_req_ready = 1'b1;
    tick;
    mif.mem_req_ready = 1'b0;
    check("wait_busy", 32'(req_ready), 32'd0);
    check("wait_addr", mif.mem_addr, 32'h8000_0010);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    tick;
    rst_n = 1'b1;
    mif.mem_resp_valid = 1'b1;
    mif.mem_rdata = 32'hCAFE_F00D;
    tick;
    mif.mem_resp_valid = 1'b0;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_resp",  32'(resp_valid), 32'd0);
    check("post_rst_mreq",  32'(mif.mem_req_valid), 32'd0);
    do_op(vt[9].wr, vt[9].ld, vt[9].op, vt[9].a, vt[9].wd, vt[9].rw, 0, 0, 0);
    compare("post_rst_lw", 1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'b0000, 32'h1234_5678, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
